// File: rtl/voxel_pkg.sv
// Shared definitions for the voxel cube driver: scheduler states and shift-engine command encodings.
// Also holds a small constant helper used to size counters at elaboration.
package voxel_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BLANK_CTRL,
    CTRL_ISSUE,
    CTRL_WAIT,
    BLANK,
    GS_ISSUE,
    GS_WAIT,
    SHOW
  } sched_state_t;

  // Bits per latch in the driver chain, shared with the shift engine.
  localparam int LATCH_SIZE = 769;

  localparam logic CMD_CONTROL   = 1'b1;
  localparam logic CMD_GRAYSCALE = 1'b0;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on entry to a state gives a dwell of exactly N cycles when the state exits on done.
module cycle_timer #(
  parameter int W = 16
) (
  input  logic         CLK_10M,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge CLK_10M) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/voxel_layer_scheduler.sv
// Voxel cube scan sequencer: orders control/grayscale latches, blanks around each latch, scans layers one-hot.
// Outputs registered one cycle after the deciding edge; a command holds until cmd_ready, one outstanding at most.
module voxel_layer_scheduler
  import voxel_pkg::*;
#(
  parameter int NUM_LAYERS          = 8,
  parameter int LAYER_HOLD_CYCLES   = 10000,
  parameter int BLANK_CYCLES        = 16,
  parameter int CTRL_REFRESH_FRAMES = 10,
  parameter int TIMEOUT_CYCLES      = 4096,
  parameter int LAYER_W             = $clog2(NUM_LAYERS)
) (
  input  logic                  CLK_10M,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_pending,
  output logic                  frame_swap,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic                  cmd_is_control,
  output logic [LAYER_W-1:0]    cmd_layer,
  input  logic                  shift_done,
  output logic [NUM_LAYERS-1:0] layer_en,
  output logic                  blank,
  output logic [15:0]           frame_count,
  output logic                  fault,
  output logic                  busy
);

  localparam int CNT_MAX = max_int(max_int(LAYER_HOLD_CYCLES, TIMEOUT_CYCLES), BLANK_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REF_W   = $clog2(CTRL_REFRESH_FRAMES + 1);

  localparam logic [CNT_W-1:0]   BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]   HOLD_LOAD  = CNT_W'(LAYER_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]   WAIT_LOAD  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
  localparam logic [REF_W-1:0]   REFRESH_AT = REF_W'(CTRL_REFRESH_FRAMES);

  sched_state_t       state, state_n;
  logic [LAYER_W-1:0] layer, layer_n;
  logic [REF_W-1:0]   refresh_cnt, refresh_n;
  logic [15:0]        frame_count_n;
  logic               fault_n;
  logic               frame_swap_n;
  logic               handshake;
  logic               timer_load;
  logic [CNT_W-1:0]   timer_val;
  logic               timer_done;

  cycle_timer #(
    .W (CNT_W)
  ) u_timer (
    .CLK_10M  (CLK_10M),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign handshake = cmd_valid && cmd_ready;
  assign cmd_layer = layer;

  always_ff @(posedge CLK_10M) begin
    if (reset) begin
      state          <= IDLE;
      layer          <= '0;
      refresh_cnt    <= '0;
      frame_count    <= '0;
      fault          <= 1'b0;
      frame_swap     <= 1'b0;
      cmd_valid      <= 1'b0;
      cmd_is_control <= CMD_GRAYSCALE;
      layer_en       <= '0;
      blank          <= 1'b1;
      busy           <= 1'b0;
    end else begin
      state          <= state_n;
      layer          <= layer_n;
      refresh_cnt    <= refresh_n;
      frame_count    <= frame_count_n;
      fault          <= fault_n;
      frame_swap     <= frame_swap_n;
      // Outputs are decoded from the next state so they line up with the state register.
      cmd_valid      <= (state_n == CTRL_ISSUE) || (state_n == GS_ISSUE);
      cmd_is_control <= (state_n == CTRL_ISSUE) ? CMD_CONTROL : CMD_GRAYSCALE;
      layer_en       <= (state_n == SHOW) ? (NUM_LAYERS'(1) << layer_n) : '0;
      blank          <= (state_n != SHOW);
      busy           <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n       = state;
    layer_n       = layer;
    refresh_n     = refresh_cnt;
    frame_count_n = frame_count;
    fault_n       = fault;
    frame_swap_n  = 1'b0;

    unique case (state)
      IDLE: begin
        if (enable) state_n = CTRL_ISSUE;
      end
      BLANK_CTRL: begin
        if (timer_done) state_n = CTRL_ISSUE;
      end
      CTRL_ISSUE: begin
        if (handshake) state_n = CTRL_WAIT;
      end
      CTRL_WAIT: begin
        if (shift_done) begin
          layer_n   = '0;
          refresh_n = '0;
          state_n   = enable ? BLANK : IDLE;
        end else if (timer_done) begin
          fault_n = 1'b1;
          state_n = enable ? BLANK_CTRL : IDLE;
        end
      end
      BLANK: begin
        if (timer_done) state_n = GS_ISSUE;
      end
      GS_ISSUE: begin
        if (handshake) state_n = GS_WAIT;
      end
      GS_WAIT: begin
        if (shift_done) begin
          state_n = enable ? SHOW : IDLE;
        end else if (timer_done) begin
          fault_n = 1'b1;
          state_n = enable ? BLANK_CTRL : IDLE;
        end
      end
      SHOW: begin
        if (timer_done) begin
          if (layer != LAST_LAYER) begin
            layer_n = layer + LAYER_W'(1);
            state_n = BLANK;
          end else begin
            // Frame boundary: swap request rides on the first cycle after the last layer.
            layer_n       = '0;
            frame_count_n = frame_count + 16'd1;
            refresh_n     = refresh_cnt + REF_W'(1);
            frame_swap_n  = frame_pending;
            state_n       = (refresh_n >= REFRESH_AT) ? BLANK_CTRL : BLANK;
          end
          if (!enable) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Every timed state is entered from a different state, so a state change is the reload point.
  always_comb begin
    timer_load = (state_n != state);
    timer_val  = '0;
    case (state_n)
      BLANK, BLANK_CTRL:  timer_val = BLANK_LOAD;
      CTRL_WAIT, GS_WAIT: timer_val = WAIT_LOAD;
      SHOW:               timer_val = HOLD_LOAD;
      default:            timer_val = '0;
    endcase
  end

endmodule

// File: tb/tb_voxel_layer_scheduler.sv
// Directed scoreboard bench for voxel_layer_scheduler with a small shift-engine responder.
// Expected commands and layer drives are queued as stimulus is planned and popped as the DUT produces them.
module tb_voxel_layer_scheduler;

  localparam int NL   = 4;
  localparam int HOLD = 8;
  localparam int BLK  = 2;
  localparam int REF  = 2;
  localparam int TMO  = 32;
  localparam int LW   = 2;

  logic          CLK_10M = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          frame_pending = 1'b0;
  logic          cmd_ready = 1'b0;
  logic          shift_done = 1'b0;
  logic          frame_swap, cmd_valid, cmd_is_control, blank, fault, busy;
  logic [LW-1:0] cmd_layer;
  logic [NL-1:0] layer_en;
  logic [15:0]   frame_count;

  int checks = 0;
  int errors = 0;
  int swap_cnt = 0;
  int viol = 0;

  typedef struct {
    logic          ctrl;
    logic [LW-1:0] layer;
    int            gap;
  } cmd_exp_t;

  cmd_exp_t      exp_cmd[$];
  logic [NL-1:0] exp_show[$];

  voxel_layer_scheduler #(
    .NUM_LAYERS          (NL),
    .LAYER_HOLD_CYCLES   (HOLD),
    .BLANK_CYCLES        (BLK),
    .CTRL_REFRESH_FRAMES (REF),
    .TIMEOUT_CYCLES      (TMO),
    .LAYER_W             (LW)
  ) dut (
    .CLK_10M        (CLK_10M),
    .reset          (reset),
    .enable         (enable),
    .frame_pending  (frame_pending),
    .frame_swap     (frame_swap),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_is_control (cmd_is_control),
    .cmd_layer      (cmd_layer),
    .shift_done     (shift_done),
    .layer_en       (layer_en),
    .blank          (blank),
    .frame_count    (frame_count),
    .fault          (fault),
    .busy           (busy)
  );

  always #5 CLK_10M = ~CLK_10M;

  always @(negedge CLK_10M) begin
    if (frame_swap === 1'b1) swap_cnt++;
    if (blank === 1'b1 && layer_en !== '0) viol++;
    if ((^layer_en) !== 1'bx && !$onehot0(layer_en)) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion, required completion within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic ctrl, input int layer, input int gap);
    cmd_exp_t e;
    e.ctrl  = ctrl;
    e.layer = LW'(layer);
    e.gap   = gap;
    exp_cmd.push_back(e);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cmd_valid"}, cmd_valid, 0);
    chk({tag, "_cmd_is_control"}, cmd_is_control, 0);
    chk({tag, "_cmd_layer"}, cmd_layer, 0);
    chk({tag, "_layer_en"}, layer_en, 0);
    chk({tag, "_blank"}, blank, 1);
    chk({tag, "_frame_swap"}, frame_swap, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Called on a negedge: waits for a command, checks it, handshakes after ready_delay cycles.
  task automatic serve_cmd(input int ready_delay, input bit give_done);
    int       w;
    cmd_exp_t e;
    w = 0;
    while (cmd_valid !== 1'b1 && w < 100) begin
      @(negedge CLK_10M);
      w++;
    end
    chk("cmd_valid_seen", cmd_valid, 1);
    chk("cmd_expected", (exp_cmd.size() > 0), 1);
    if (exp_cmd.size() == 0) return;
    e = exp_cmd.pop_front();
    chk("cmd_gap", w, e.gap);
    chk("cmd_is_control", cmd_is_control, e.ctrl);
    chk("cmd_blank", blank, 1);
    if (!e.ctrl) chk("cmd_layer", cmd_layer, e.layer);
    for (int i = 1; i < ready_delay; i++) begin
      @(negedge CLK_10M);
      chk("hold_valid", cmd_valid, 1);
      chk("hold_ctrl", cmd_is_control, e.ctrl);
      if (!e.ctrl) chk("hold_layer", cmd_layer, e.layer);
    end
    cmd_ready = 1'b1;
    @(negedge CLK_10M);
    cmd_ready = 1'b0;
    chk("valid_drop", cmd_valid, 0);
    chk("busy_wait", busy, 1);
    if (give_done) begin
      repeat (4) @(negedge CLK_10M);
      shift_done = 1'b1;
      @(negedge CLK_10M);
      shift_done = 1'b0;
    end
  endtask

  // Watches one SHOW interval; drop_at >= 0 lowers enable that many cycles into it.
  task automatic watch_show(input int drop_at);
    int            w;
    int            n;
    logic [NL-1:0] e;
    w = 0;
    n = 0;
    while (layer_en === '0 && w < 50) begin
      @(negedge CLK_10M);
      w++;
    end
    chk("show_gap", w, 0);
    chk("show_expected", (exp_show.size() > 0), 1);
    if (exp_show.size() == 0) return;
    e = exp_show.pop_front();
    chk("layer_en", layer_en, e);
    chk("blank_show", blank, 0);
    while (layer_en !== '0 && n < 100) begin
      if (n == drop_at) enable = 1'b0;
      n++;
      @(negedge CLK_10M);
    end
    chk("hold_len", n, HOLD);
    chk("blank_after", blank, 1);
  endtask

  task automatic run_frame(input bit pend);
    for (int l = 0; l < NL; l++) begin
      push_cmd(1'b0, l, BLK);
      exp_show.push_back(NL'(1) << l);
      serve_cmd(3, 1'b1);
      if (l == NL - 1) frame_pending = pend;
      watch_show(-1);
      frame_pending = 1'b0;
    end
  endtask

  initial begin
    int w;

    repeat (3) @(negedge CLK_10M);
    check_reset_values("rst");
    reset = 1'b0;
    @(negedge CLK_10M);
    chk("idle_busy", busy, 0);

    // Bring-up: control latch one cycle after enable.
    enable = 1'b1;
    push_cmd(1'b1, 0, 1);
    serve_cmd(3, 1'b1);

    run_frame(1'b0);
    chk("frame_count_1", frame_count, 1);
    run_frame(1'b1);
    chk("frame_count_2", frame_count, 2);

    // Second frame end reaches the refresh count: one control latch, then layer 0.
    push_cmd(1'b1, 0, BLK);
    serve_cmd(3, 1'b1);
    chk("swap_after_pending", swap_cnt, 1);
    run_frame(1'b0);
    chk("frame_count_3", frame_count, 3);

    // Stall: ready withheld for 10 cycles.
    push_cmd(1'b0, 0, BLK);
    exp_show.push_back(4'b0001);
    serve_cmd(11, 1'b1);
    chk("swap_no_pending", swap_cnt, 1);
    watch_show(-1);

    // Timeout: shift_done never arrives for layer 1.
    push_cmd(1'b0, 1, BLK);
    serve_cmd(3, 1'b0);
    w = 0;
    while (fault !== 1'b1 && w < 100) begin
      @(negedge CLK_10M);
      w++;
    end
    chk("timeout_len", w, TMO);
    chk("timeout_blank", blank, 1);
    chk("timeout_layer_en", layer_en, 0);
    push_cmd(1'b1, 0, BLK);
    serve_cmd(3, 1'b1);
    chk("fault_sticky", fault, 1);
    push_cmd(1'b0, 0, BLK);
    exp_show.push_back(4'b0001);
    serve_cmd(3, 1'b1);
    watch_show(-1);

    // Stop: enable dropped mid-SHOW of layer 1.
    push_cmd(1'b0, 1, BLK);
    exp_show.push_back(4'b0010);
    serve_cmd(3, 1'b1);
    watch_show(3);
    chk("stop_busy", busy, 0);
    chk("stop_layer_en", layer_en, 0);
    repeat (5) @(negedge CLK_10M);
    chk("stop_idle_valid", cmd_valid, 0);
    chk("stop_idle_busy", busy, 0);
    chk("stop_frame_count", frame_count, 3);

    // Restart, then reset while waiting for a grayscale shift.
    enable = 1'b1;
    push_cmd(1'b1, 0, 1);
    serve_cmd(3, 1'b1);
    push_cmd(1'b0, 0, BLK);
    serve_cmd(3, 1'b0);
    @(negedge CLK_10M);
    reset = 1'b1;
    @(negedge CLK_10M);
    check_reset_values("rst_mid");
    reset = 1'b0;
    enable = 1'b0;
    @(negedge CLK_10M);

    chk("swap_total", swap_cnt, 1);
    chk("blank_onehot_invariant", viol, 0);
    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("show_queue_drained", exp_show.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/voxel_layer_scheduler.md
Name: voxel_layer_scheduler

Overview:
- Top-level sequencer for the voxel cube LED driver chain. Decides when the 769-bit shift engine sends a control latch or a grayscale latch, and for which layer.
- Time-multiplexes the one-hot layer drives and blanks the outputs around every latch.
- Forces a periodic control-latch refresh and requests front/back frame-buffer swaps at frame boundaries.
- Sits between the host frame buffer and the SDO/SCLK/LAT shift engine.

Parameters:
- NUM_LAYERS, 8, number of cube layers scanned per frame
- LAYER_HOLD_CYCLES, 10000, CLK_10M cycles each layer stays lit
- BLANK_CYCLES, 16, cycles with blank=1 and layer_en=0 before each shift command
- CTRL_REFRESH_FRAMES, 10, frames between control-latch refreshes
- TIMEOUT_CYCLES, 4096, maximum wait for shift_done before a fault is declared
- LAYER_W, $clog2(NUM_LAYERS), width of the layer index

Ports:
- CLK_10M  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run scan; low means stop at the next safe point
- frame_pending  in  1  host has a complete frame in the back buffer
- frame_swap  out  1  one-cycle pulse: swap front/back buffers
- cmd_valid  out  1  shift command request to the shift engine
- cmd_ready  in  1  shift engine accepts the command this cycle
- cmd_is_control  out  1  1 = control latch, 0 = grayscale latch
- cmd_layer  out  LAYER_W  layer whose grayscale data is shifted
- shift_done  in  1  one-cycle pulse: shift engine has asserted LAT
- layer_en  out  NUM_LAYERS  one-hot layer drive
- blank  out  1  forces driver outputs off
- frame_count  out  16  completed frames, wraps at 2^16
- fault  out  1  sticky shift timeout flag, cleared only by reset
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, CLK_10M. Reset is synchronous and active-high.
- Reset values: cmd_valid=0, cmd_is_control=0, cmd_layer=0, layer_en=0, blank=1, frame_swap=0, frame_count=0, fault=0, busy=0, state=IDLE, refresh counter=0.
- Reset asserted mid-operation takes effect on the next edge with no draining.
- All outputs are registered.
- States:
  - IDLE: blank=1, layer_en=0. If enable is sampled 1 at edge t, state goes to CTRL_ISSUE and cmd_valid=1 at t+1.
  - CTRL_ISSUE: cmd_valid=1, cmd_is_control=1. On cmd_valid&&cmd_ready, go to CTRL_WAIT.
  - CTRL_WAIT: on shift_done, set layer=0, clear refresh counter, go to BLANK.
  - BLANK: layer_en=0, blank=1 for exactly BLANK_CYCLES cycles, then GS_ISSUE.
  - GS_ISSUE: cmd_valid=1, cmd_is_control=0, cmd_layer=layer. On handshake, go to GS_WAIT.
  - GS_WAIT: on shift_done, go to SHOW.
  - SHOW: layer_en=1<<layer, blank=0 for exactly LAYER_HOLD_CYCLES cycles.
- End of SHOW:
  - If layer<NUM_LAYERS-1: layer++, go to BLANK.
  - Else (frame end): frame_count++; refresh counter++. If frame_pending was sampled high in the last SHOW cycle, pulse frame_swap in the first BLANK or CTRL cycle. If the refresh counter has reached CTRL_REFRESH_FRAMES, go to BLANK_CTRL (blank for BLANK_CYCLES) then CTRL_ISSUE; otherwise layer=0 and go to BLANK.
- Handshake rules:
  - Once asserted, cmd_valid, cmd_is_control and cmd_layer hold stable until cmd_ready is sampled high.
  - cmd_valid deasserts the cycle after the handshake.
  - At most one outstanding command.
  - shift_done is honoured only in CTRL_WAIT and GS_WAIT; elsewhere it is ignored.
- Timeout: in CTRL_WAIT or GS_WAIT, if shift_done has not arrived after TIMEOUT_CYCLES, set fault=1 and go to BLANK_CTRL (full control re-init).
- enable deasserted:
  - In ISSUE states, the handshake completes first; the matching WAIT completes normally.
  - The scheduler then goes to IDLE at the next end of SHOW or end of WAIT, whichever comes first.
  - In IDLE, blank=1 and layer_en=0.
- layer_en is never non-zero while blank=1, and never has more than one bit set.
- Counter widths:
  - The hold/blank/timeout counter is sized for max(LAYER_HOLD_CYCLES, TIMEOUT_CYCLES).
  - The refresh counter is $clog2(CTRL_REFRESH_FRAMES+1).

Decomposition:
- Package voxel_pkg holds:
  - the sched_state_t enum: IDLE, BLANK_CTRL, CTRL_ISSUE, CTRL_WAIT, BLANK, GS_ISSUE, GS_WAIT, SHOW;
  - LATCH_SIZE=769 and CMD_CONTROL/CMD_GRAYSCALE encodings, shared with the shift engine.
- One sub-module, cycle_timer: a loadable down-counter with a done flag, reused for the blank, hold and timeout intervals.

Test Plan (NUM_LAYERS=4, LAYER_HOLD_CYCLES=8, BLANK_CYCLES=2, CTRL_REFRESH_FRAMES=2, TIMEOUT_CYCLES=32; the engine model raises cmd_ready 3 cycles after cmd_valid and pulses shift_done 5 cycles after the handshake):
- Bring-up: reset, then enable=1 -> cmd_valid with cmd_is_control=1 one cycle later; after the control shift_done: blank for 2 cycles, grayscale command with cmd_layer=0, then layer_en=4'b0001 for exactly 8 cycles.
- Layer scan: run one frame -> layer_en sequence 0001, 0010, 0100, 1000, each separated by 2 blank cycles plus a grayscale handshake; frame_count becomes 1.
- Refresh: run 2 frames -> exactly one control command after frame 2 (refresh counter reset), frame_count=2, then layer 0 resumes.
- Swap: frame_pending=1 during the layer-3 SHOW -> single one-cycle frame_swap pulse at the frame boundary; frame_pending=0 -> no pulse.
- Stall/timeout: hold cmd_ready low for 10 cycles -> cmd_valid and cmd_layer stable throughout; withhold shift_done for 32 cycles -> fault=1, blank=1, then a control command is reissued.
- Stop and reset: drop enable during SHOW -> IDLE after that SHOW ends with layer_en=0; reset asserted in GS_WAIT -> all outputs at reset values on the next edge.
